// File: rtl/fixed_to_float_converter_pkg.sv
// Shared float-conversion definitions: FSM state encoding and IEEE-754 single field layout.
// Also used by the float-to-fixed path.
package fixed_to_float_converter_pkg;

  localparam int F_EXP_W   = 8;
  localparam int F_MAN_W   = 23;
  localparam int F_BIAS    = 127;
  localparam int F_WIDTH   = 1 + F_EXP_W + F_MAN_W;
  localparam int F_SIGN_OFF = F_WIDTH - 1;
  localparam int F_EXP_OFF  = F_MAN_W;
  localparam int F_MAN_OFF  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } conv_state_t;

endpackage

// File: rtl/fixed_to_float_round_pack.sv
// Combinational mantissa extraction, round-to-nearest-even and IEEE field packing.
module fixed_to_float_round_pack
  import fixed_to_float_converter_pkg::*;
#(
  parameter int FIXED_W = 32,
  parameter int EXP_W   = F_EXP_W,
  parameter int MAN_W   = F_MAN_W
) (
  input  logic                     sign,
  input  logic [EXP_W-1:0]         exp_in,
  input  logic [FIXED_W-2:0]       m_frac,
  output logic [EXP_W+MAN_W:0]     float_out
);

  // Left-align the bits below the hidden one into a field wide enough for man, G and St;
  // narrow inputs are zero-padded so G and St fall out as zero.
  localparam int PW = (FIXED_W - 1 > MAN_W + 2) ? FIXED_W - 1 : MAN_W + 2;
  localparam int SH = PW - (FIXED_W - 1);

  logic [PW-1:0]    frac;
  logic [MAN_W-1:0] man;
  logic             guard;
  logic             sticky;
  logic             rnd_up;
  logic [MAN_W:0]   man_sum;
  logic [EXP_W-1:0] exp_adj;

  always_comb begin
    frac    = PW'(m_frac) << SH;
    man     = frac[PW-1 -: MAN_W];
    guard   = frac[PW-1-MAN_W];
    sticky  = |frac[PW-MAN_W-2:0];
    rnd_up  = guard & (sticky | man[0]);
    man_sum = {1'b0, man} + (MAN_W+1)'(rnd_up);
    // Carry out means the mantissa wrapped to all zeros: bump the exponent.
    exp_adj = exp_in + EXP_W'(man_sum[MAN_W]);
    float_out = {sign, exp_adj, man_sum[MAN_W-1:0]};
  end

endmodule

// File: rtl/fixed_to_float_converter.sv
// Multi-cycle signed fixed-point to IEEE-754 converter with Begin/ACK handshake.
// Normalises one bit per cycle, then rounds (RNE) and packs.
module fixed_to_float_converter
  import fixed_to_float_converter_pkg::*;
#(
  parameter int FIXED_W = 32,
  parameter int FRAC_W  = 23,
  parameter int EXP_W   = F_EXP_W,
  parameter int MAN_W   = F_MAN_W,
  parameter int BIAS    = F_BIAS
) (
  input  logic                   CLK,
  input  logic                   RST_FF,
  input  logic                   Begin_FSM_FF,
  input  logic [FIXED_W-1:0]     Fixed_in,
  output logic [EXP_W+MAN_W:0]   Float_out,
  output logic                   ACK_FF,
  output logic                   Busy
);

  localparam int E_W    = EXP_W + 2;
  localparam int E_INIT = BIAS + (FIXED_W - 1 - FRAC_W);

  if (!((E_INIT + 1 < (1 << EXP_W) - 1) && (E_INIT - (FIXED_W - 1) >= 1))) begin : g_bad_params
    $error("fixed_to_float_converter: exponent range overflows or goes denormal");
  end

  conv_state_t              state_q, state_d;
  logic [FIXED_W-1:0]       x_q;
  logic [FIXED_W-1:0]       m_q;
  logic [E_W-1:0]           e_q;
  logic                     s_q;
  logic [EXP_W+MAN_W:0]     packed_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Begin_FSM_FF) state_d = ST_ABS;
      ST_ABS:   state_d = (x_q == '0) ? ST_DONE : ST_NORM;
      ST_NORM:  if (m_q[FIXED_W-1]) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (!Begin_FSM_FF) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      m_q       <= '0;
      e_q       <= '0;
      s_q       <= 1'b0;
      Float_out <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (Begin_FSM_FF) x_q <= Fixed_in;
        ST_ABS: begin
          // Unsigned negate: the most-negative input lands exactly on 2^(FIXED_W-1).
          s_q <= x_q[FIXED_W-1];
          m_q <= x_q[FIXED_W-1] ? -x_q : x_q;
          e_q <= E_W'(E_INIT);
          if (x_q == '0) Float_out <= '0;
        end
        ST_NORM: if (!m_q[FIXED_W-1]) begin
          m_q <= m_q << 1;
          e_q <= e_q - E_W'(1);
        end
        ST_ROUND: Float_out <= packed_w;
        default: ;
      endcase
    end
  end

  fixed_to_float_round_pack #(
    .FIXED_W (FIXED_W),
    .EXP_W   (EXP_W),
    .MAN_W   (MAN_W)
  ) u_round_pack (
    .sign      (s_q),
    .exp_in    (e_q[EXP_W-1:0]),
    .m_frac    (m_q[FIXED_W-2:0]),
    .float_out (packed_w)
  );

  assign ACK_FF = (state_q == ST_DONE);
  assign Busy   = (state_q == ST_ABS) || (state_q == ST_NORM) || (state_q == ST_ROUND);

endmodule

// File: tb/tb_fixed_to_float_converter.sv
// Scoreboard bench: stimulus pushes expected {value, latency}; a monitor checks on each ACK rise.
module tb_fixed_to_float_converter;

  logic        CLK = 1'b0;
  logic        RST_FF;
  logic        Begin_FSM_FF;
  logic [31:0] Fixed_in;
  logic [31:0] Float_out;
  logic        ACK_FF;
  logic        Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          start_q[$];

  fixed_to_float_converter dut (
    .CLK          (CLK),
    .RST_FF       (RST_FF),
    .Begin_FSM_FF (Begin_FSM_FF),
    .Fixed_in     (Fixed_in),
    .Float_out    (Float_out),
    .ACK_FF       (ACK_FF),
    .Busy         (Busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: value = X / 2^23, rounded to nearest-even by remainder comparison.
  function automatic logic [31:0] ref_float(input logic [31:0] v);
    longint mag, q, rem, half;
    int pos, sh, ex;
    logic s;
    s = v[31];
    mag = s ? (64'sd4294967296 - longint'(v)) : longint'(v);
    if (mag == 0) return 32'h0;
    pos = 0;
    for (int i = 0; i < 33; i++) if (((mag >> i) & 1) == 1) pos = i;
    ex = pos - 23 + 127;
    if (pos > 23) begin
      sh = pos - 23;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        ex = ex + 1;
      end
    end else begin
      q = mag << (23 - pos);
    end
    return {s, ex[7:0], q[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] v);
    logic [31:0] mag;
    int lz;
    mag = v[31] ? -v : v;
    if (mag == 0) return 2;
    lz = 0;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) break;
      lz++;
    end
    return 4 + lz;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare on every ACK rising edge, independent of the stimulus thread.
  logic ack_prev = 1'b0;
  always @(negedge CLK) begin
    if (ACK_FF && !ack_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=%h required=none", Float_out);
      end else begin
        logic [31:0] e;
        int l, st;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        st = start_q.pop_front();
        check("float_out", Float_out, e);
        check("latency", cyc - st + 1, l);
      end
    end
    ack_prev <= ACK_FF;
  end

  // One conversion; Fixed_in is scrambled while busy and Begin held 'hold' extra cycles in DONE.
  task automatic run(input logic [31:0] v, input logic [31:0] e, input int lat, input int hold);
    bit seen;
    @(negedge CLK);
    Fixed_in = v;
    Begin_FSM_FF = 1'b1;
    exp_q.push_back(e);
    lat_q.push_back(lat);
    start_q.push_back(cyc + 1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (ACK_FF) begin
        seen = 1;
        break;
      end
      Fixed_in = $urandom;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout actual=0 required=1 input=%h", v);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("ack_held", {31'b0, ACK_FF}, 32'd1);
      check("busy_held", {31'b0, Busy}, 32'd0);
    end
    Begin_FSM_FF = 1'b0;
    @(negedge CLK);
    check("ack_drop", {31'b0, ACK_FF}, 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    bit drained;
    RST_FF = 1'b1;
    Begin_FSM_FF = 1'b0;
    Fixed_in = '0;
    repeat (3) @(negedge CLK);
    check("rst_float", Float_out, 32'h0);
    check("rst_ack", {31'b0, ACK_FF}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    RST_FF = 1'b0;

    run(32'h0080_0000, 32'h3F80_0000, 12, 0);
    run(32'hFF80_0000, 32'hBF80_0000, 12, 0);
    run(32'h8000_0000, 32'hC380_0000, 4, 0);
    run(32'h7FFF_FFFF, 32'h4380_0000, 5, 0);
    run(32'h0100_0001, 32'h4000_0000, 11, 0);
    check("hold_idle", Float_out, 32'h4000_0000);

    // Zero: Busy only in ABS, ACK on the second edge
    @(negedge CLK);
    Fixed_in = 32'h0;
    Begin_FSM_FF = 1'b1;
    exp_q.push_back(32'h0);
    lat_q.push_back(2);
    start_q.push_back(cyc + 1);
    @(negedge CLK);
    check("zero_busy_abs", {31'b0, Busy}, 32'd1);
    @(negedge CLK);
    check("zero_busy_done", {31'b0, Busy}, 32'd0);
    check("zero_ack", {31'b0, ACK_FF}, 32'd1);
    Begin_FSM_FF = 1'b0;
    @(negedge CLK);

    // Reset mid-normalisation abandons the run
    Fixed_in = 32'h0000_0001;
    Begin_FSM_FF = 1'b1;
    repeat (6) @(negedge CLK);
    check("busy_in_norm", {31'b0, Busy}, 32'd1);
    Begin_FSM_FF = 1'b0;
    #1 RST_FF = 1'b1;
    #2;
    check("midrst_float", Float_out, 32'h0);
    check("midrst_busy", {31'b0, Busy}, 32'd0);
    RST_FF = 1'b0;
    repeat (40) @(negedge CLK);
    check("midrst_no_ack", {31'b0, ACK_FF}, 32'd0);
    check("midrst_float_hold", Float_out, 32'h0);

    run(32'h0080_0000, 32'h3F80_0000, 12, 0);
    run(32'hFFFF_FFFF, ref_float(32'hFFFF_FFFF), ref_lat(32'hFFFF_FFFF), 5);
    run(32'h0000_0003, ref_float(32'h0000_0003), ref_lat(32'h0000_0003), 0);

    for (int n = 0; n < 40; n++) begin
      v = $urandom;
      if (n % 4 == 1) v = v >> $urandom_range(31, 0);
      if (n % 4 == 2) v = -(v >> $urandom_range(31, 8));
      run(v, ref_float(v), ref_lat(v), n % 3);
    end

    drained = 0;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) begin
        drained = 1;
        break;
      end
      @(negedge CLK);
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
